// File: rtl/nibble_serial_adder.sv
// Multi-word adder that consumes operand nibbles LSB-first, chains the carry
// between slices, and hands the assembled sum, carry-out and overflow downstream.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_a,
    input  logic [3:0]             in_b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   out_ovf,
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [W-1:0]    sum_r, sum_s;
    logic            carry_r, carry_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            cout_r, cout_s;
    logic            ovf_r, ovf_s;
    logic            in_ready_r, out_valid_r, busy_r;
    logic            accept_s, last_s, carry_in_s;
    logic [4:0]      add_s;

    // 4-bit ripple-carry stage: {carry_out, sum} of a + b + ci
    function automatic logic [4:0] nibble_add(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic       ci);
        return {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    endfunction

    assign accept_s   = in_valid && in_ready_r;
    assign carry_in_s = (state_r == IDLE) ? cin : carry_r;
    assign add_s      = nibble_add(in_a, in_b, carry_in_s);
    assign last_s     = (cnt_r == LAST_IDX);

    // Next-state and datapath update for the slice sequencer
    always_comb begin
        state_s = state_r;
        sum_s   = sum_r;
        carry_s = carry_r;
        cnt_s   = cnt_r;
        cout_s  = cout_r;
        ovf_s   = ovf_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    sum_s      = {W{1'b0}};
                    sum_s[3:0] = add_s[3:0];
                    carry_s    = add_s[4];
                    cnt_s      = CW'(1);
                    if (last_s) begin
                        state_s = DONE;
                        cout_s  = add_s[4];
                        ovf_s   = (in_a[3] ^ in_b[3] ^ add_s[3]) ^ add_s[4];
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    sum_s[4*int'(cnt_r) +: 4] = add_s[3:0];
                    carry_s = add_s[4];
                    cnt_s   = cnt_r + CW'(1);
                    if (last_s) begin
                        state_s = DONE;
                        cout_s  = add_s[4];
                        // carry into the MSB is recovered from the slice's own bit 3
                        ovf_s   = (in_a[3] ^ in_b[3] ^ add_s[3]) ^ add_s[4];
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            sum_r       <= {W{1'b0}};
            carry_r     <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            sum_r       <= sum_s;
            carry_r     <= carry_s;
            cnt_r       <= cnt_s;
            cout_r      <= cout_s;
            ovf_r       <= ovf_s;
            in_ready_r  <= (state_s != DONE);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = sum_r;
    assign out_cout  = cout_r;
    assign out_ovf   = ovf_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 4-nibble instance plus a 1-nibble
// instance, with hand-computed expected sums, carries and overflow flags.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, out_valid, out_ready, out_cout, out_ovf, busy;
    logic [3:0]  in_a, in_b;
    logic [15:0] out_sum;

    logic        in_valid_n1, in_ready_n1, cin_n1, out_valid_n1, out_ready_n1;
    logic        out_cout_n1, out_ovf_n1, busy_n1;
    logic [3:0]  in_a_n1, in_b_n1, out_sum_n1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .out_ovf(out_ovf), .busy(busy)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut_n1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_n1), .in_ready(in_ready_n1),
        .in_a(in_a_n1), .in_b(in_b_n1), .cin(cin_n1), .out_valid(out_valid_n1),
        .out_ready(out_ready_n1), .out_sum(out_sum_n1), .out_cout(out_cout_n1),
        .out_ovf(out_ovf_n1), .busy(busy_n1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed one 16-bit operation LSB-first; optional idle gap after nibble 1
    task automatic send_op(input logic [15:0] a, input logic [15:0] b,
                           input logic c, input int gap);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = a[4*i +: 4];
            in_b     = b[4*i +: 4];
            cin      = c;
            check("in_ready_before_accept", in_ready, 1);
            tick();
            if (i < 3) check("no_early_valid", out_valid, 0);
            if (i == 1 && gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) begin
                    tick();
                    check("gap_busy", busy, 1);
                    check("gap_no_valid", out_valid, 0);
                end
            end
        end
        in_valid = 1'b0;
        check("valid_after_last", out_valid, 1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] s,
                                input logic co, input logic ov);
        check({tag, "_sum"},  out_sum,  s);
        check({tag, "_cout"}, out_cout, co);
        check({tag, "_ovf"},  out_ovf,  ov);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = 4'h0; in_b = 4'h0; cin = 1'b0; out_ready = 1'b1;
        in_valid_n1 = 1'b0; in_a_n1 = 4'h0; in_b_n1 = 4'h0; cin_n1 = 1'b0; out_ready_n1 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check_result("rst", 16'h0000, 1'b0, 1'b0);
        check("rst_n1_valid", out_valid_n1, 0);

        // 0x1234 + 0x0FCD with the consumer stalled
        out_ready = 1'b0;
        send_op(16'h1234, 16'h0FCD, 1'b0, 0);
        check_result("add1", 16'h2201, 1'b0, 1'b0);
        check("done_in_ready", in_ready, 0);
        check("done_busy", busy, 1);
        in_valid = 1'b1; in_a = 4'h5; in_b = 4'h6; cin = 1'b0;
        repeat (5) begin
            tick();
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check_result("bp", 16'h2201, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_busy", busy, 0);
        tick();
        check("pending_nib0_sum", out_sum, 16'h000B);
        check("pending_busy", busy, 1);
        in_a = 4'h0; in_b = 4'h0;
        repeat (3) tick();
        check("pending_valid", out_valid, 1);
        check_result("pending", 16'h000B, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        check("done_one_cycle", out_valid, 0);

        send_op(16'h7FFF, 16'h0001, 1'b0, 0);
        check_result("ovf", 16'h8000, 1'b0, 1'b1);
        tick();

        send_op(16'hFFFF, 16'h0000, 1'b1, 0);
        check_result("cin_wrap", 16'h0000, 1'b1, 1'b0);
        tick();
        send_op(16'h0001, 16'h0001, 1'b0, 0);
        check_result("no_stale_carry", 16'h0002, 1'b0, 1'b0);
        tick();

        send_op(16'h1234, 16'h0FCD, 1'b0, 3);
        check_result("gap", 16'h2201, 1'b0, 1'b0);
        tick();

        // Reset mid-operation with a handshake still offered
        in_valid = 1'b1; in_a = 4'h1; in_b = 4'h1; cin = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sum", out_sum, 16'h0000);
        check("midrst_in_ready", in_ready, 1);
        rst = 1'b0;
        in_valid = 1'b0;
        send_op(16'h0003, 16'h0004, 1'b0, 0);
        check_result("post_rst", 16'h0007, 1'b0, 1'b0);
        tick();

        // Single-nibble build: 9 + 8
        in_valid_n1 = 1'b1; in_a_n1 = 4'h9; in_b_n1 = 4'h8; cin_n1 = 1'b0;
        check("n1_ready", in_ready_n1, 1);
        tick();
        in_valid_n1 = 1'b0;
        check("n1_valid", out_valid_n1, 1);
        check("n1_sum", out_sum_n1, 4'h1);
        check("n1_cout", out_cout_n1, 1);
        check("n1_ovf", out_ovf_n1, 1);
        check("n1_in_ready_done", in_ready_n1, 0);
        tick();
        check("n1_valid_drop", out_valid_n1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
